// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment read-back path.
// Patterns are active-low: bit 7 is the dot, bits 6:0 are segments g..a.
package seg7_pkg;

    localparam logic [7:0] SEG7_GLYPH_0 = 8'hC0;
    localparam logic [7:0] SEG7_GLYPH_1 = 8'hF9;
    localparam logic [7:0] SEG7_GLYPH_2 = 8'hA4;
    localparam logic [7:0] SEG7_GLYPH_3 = 8'hB0;
    localparam logic [7:0] SEG7_GLYPH_4 = 8'h99;
    localparam logic [7:0] SEG7_GLYPH_5 = 8'h92;
    localparam logic [7:0] SEG7_GLYPH_6 = 8'h82;
    localparam logic [7:0] SEG7_GLYPH_7 = 8'hF8;
    localparam logic [7:0] SEG7_GLYPH_8 = 8'h80;
    localparam logic [7:0] SEG7_GLYPH_9 = 8'h98;
    localparam logic [7:0] SEG7_GLYPH_A = 8'h88;
    localparam logic [7:0] SEG7_GLYPH_B = 8'h83;
    localparam logic [7:0] SEG7_GLYPH_C = 8'hC6;
    localparam logic [7:0] SEG7_GLYPH_D = 8'hA1;
    localparam logic [7:0] SEG7_GLYPH_E = 8'h86;
    localparam logic [7:0] SEG7_GLYPH_F = 8'h8E;

    // Dot lit, every segment dark.
    localparam logic [7:0] SEG7_DOT = 8'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } seg7_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph lookup: 8-bit active-low pattern -> {legal, nibble}.
// Any pattern outside the sixteen hex glyphs (including a lit dot) is illegal.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [7:0] i_pattern,
    output logic       o_legal,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_legal  = 1'b1;
        o_nibble = 4'h0;
        case (i_pattern)
            SEG7_GLYPH_0: o_nibble = 4'h0;
            SEG7_GLYPH_1: o_nibble = 4'h1;
            SEG7_GLYPH_2: o_nibble = 4'h2;
            SEG7_GLYPH_3: o_nibble = 4'h3;
            SEG7_GLYPH_4: o_nibble = 4'h4;
            SEG7_GLYPH_5: o_nibble = 4'h5;
            SEG7_GLYPH_6: o_nibble = 4'h6;
            SEG7_GLYPH_7: o_nibble = 4'h7;
            SEG7_GLYPH_8: o_nibble = 4'h8;
            SEG7_GLYPH_9: o_nibble = 4'h9;
            SEG7_GLYPH_A: o_nibble = 4'hA;
            SEG7_GLYPH_B: o_nibble = 4'hB;
            SEG7_GLYPH_C: o_nibble = 4'hC;
            SEG7_GLYPH_D: o_nibble = 4'hD;
            SEG7_GLYPH_E: o_nibble = 4'hE;
            SEG7_GLYPH_F: o_nibble = 4'hF;
            default:      o_legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Reads back a multiplexed active-low seven-segment bus: stability filter,
// glyph decode, word assembly and illegal-glyph flagging. Option: SEG7_DOT_IGNORE_EN.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                seg_in,
    input  logic [DIGITS-1:0]         dig_sel,
    input  logic                      sample_en,
    output logic [4*DIGITS-1:0]       word_out,
    output logic                      word_valid,
    output logic                      err,
    output logic [$clog2(DIGITS)-1:0] err_digit
);

    localparam int                IDX_W     = $clog2(DIGITS);
    localparam logic [3:0]        STABLE_N  = 4'(STABLE_CYCLES);
    localparam logic [DIGITS-1:0] MASK_FULL = '1;

    seg7_state_t         r_state, w_state_next;
    logic [7:0]          r_seg, w_seg_next;
    logic [DIGITS-1:0]   r_sel, w_sel_next;
    logic [3:0]          r_count, w_count_next;
    logic                w_eval;

    logic [4*DIGITS-1:0] r_slots, w_slots_upd;
    logic [DIGITS-1:0]   r_mask, w_mask_upd;
    logic [4*DIGITS-1:0] r_word_out;
    logic                r_word_valid;
    logic                r_err;
    logic [IDX_W-1:0]    r_err_digit;

    logic [7:0]          w_seg;
    logic                w_onehot;
    logic                w_qual;
    logic                w_same;
    logic                w_legal;
    logic [3:0]          w_nibble;
    logic [IDX_W-1:0]    w_idx;

`ifdef SEG7_DOT_IGNORE_EN
    assign w_seg = seg_in | ~SEG7_DOT;
`else
    assign w_seg = seg_in;
`endif

    assign w_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
    assign w_qual   = sample_en && w_onehot;
    assign w_same   = (w_seg == r_seg) && (dig_sel == r_sel);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_sel[i]) w_idx = IDX_W'(i);
        end
    end

    seg7_glyph_decode u_decode (
        .i_pattern (w_seg),
        .o_legal   (w_legal),
        .o_nibble  (w_nibble)
    );

    // Candidate slot/mask contents if the current sample is captured.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
            assign w_slots_upd[4*gi +: 4] = dig_sel[gi] ? w_nibble : r_slots[4*gi +: 4];
        end
    endgenerate
    assign w_mask_upd = r_mask | dig_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_seg_next   = r_seg;
        w_sel_next   = r_sel;
        w_count_next = r_count;
        w_eval       = 1'b0;
        if (sample_en && !w_onehot) begin
            w_state_next = IDLE;
            w_count_next = 4'd0;
        end else if (w_qual) begin
            if ((r_state == TRACK) && w_same) begin
                w_count_next = r_count + 4'd1;
            end else if ((r_state == IDLE) || !w_same) begin
                w_state_next = TRACK;
                w_seg_next   = w_seg;
                w_sel_next   = dig_sel;
                w_count_next = 4'd1;
            end
            // Reaching the threshold in TRACK (including a fresh load when it is 1) evaluates once.
            if ((w_state_next == TRACK) && (w_count_next == STABLE_N)) begin
                w_eval       = 1'b1;
                w_state_next = LOCKED;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg        <= '0;
            r_sel        <= '0;
            r_count      <= '0;
            r_slots      <= '0;
            r_mask       <= '0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
            r_err        <= 1'b0;
            r_err_digit  <= '0;
        end else begin
            r_seg        <= w_seg_next;
            r_sel        <= w_sel_next;
            r_count      <= w_count_next;
            r_word_valid <= 1'b0;
            r_err        <= 1'b0;
            if (w_eval) begin
                if (w_legal) begin
                    r_slots <= w_slots_upd;
                    if (w_mask_upd == MASK_FULL) begin
                        r_word_out   <= w_slots_upd;
                        r_word_valid <= 1'b1;
                        r_mask       <= '0;
                    end else begin
                        r_mask <= w_mask_upd;
                    end
                end else begin
                    r_err       <= 1'b1;
                    r_err_digit <= w_idx;
                end
            end
        end
    end

    assign word_out   = r_word_out;
    assign word_valid = r_word_valid;
    assign err        = r_err;
    assign err_digit  = r_err_digit;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture (DIGITS=4, STABLE_CYCLES=4) against a
// run-length reference model; honours SEG7_DOT_IGNORE_EN when defined.
module tb_seg7_capture;

    localparam int STABLE = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  dig_sel;
    logic        sample_en;
    logic [15:0] word_out;
    logic        word_valid;
    logic        err;
    logic [1:0]  err_digit;

    int checks   = 0;
    int failures = 0;

    seg7_capture #(.DIGITS(4), .STABLE_CYCLES(STABLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .dig_sel    (dig_sel),
        .sample_en  (sample_en),
        .word_out   (word_out),
        .word_valid (word_valid),
        .err        (err),
        .err_digit  (err_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: glyph table plus the length of the current run of identical
    // qualifying samples; a digit is evaluated exactly when its run reaches STABLE.
    logic [7:0]  glyphs [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0]  m_seg;
    logic [3:0]  m_sel;
    int          m_run;
    logic [3:0]  m_slots [4];
    logic [3:0]  m_mask;
    logic        exp_valid, exp_err;
    logic [15:0] exp_word;
    logic [1:0]  exp_err_digit;

    task automatic model_reset();
        m_seg = 8'h00; m_sel = 4'h0; m_run = 0; m_mask = 4'h0;
        for (int i = 0; i < 4; i++) m_slots[i] = 4'h0;
        exp_valid = 1'b0; exp_err = 1'b0; exp_word = 16'h0; exp_err_digit = 2'd0;
    endtask

    task automatic model_step(input logic en, input logic [7:0] seg, input logic [3:0] sel);
        logic [7:0] s;
        int idx;
        int nib;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (!en) return;
        if ($countones(sel) != 1) begin
            m_run = 0;
            return;
        end
        s = seg;
`ifdef SEG7_DOT_IGNORE_EN
        s[7] = 1'b1;
`endif
        if (m_run > 0 && s == m_seg && sel == m_sel) m_run++;
        else begin
            m_run = 1; m_seg = s; m_sel = sel;
        end
        if (m_run == STABLE) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
            nib = -1;
            for (int g = 0; g < 16; g++) if (glyphs[g] == s) nib = g;
            if (nib >= 0) begin
                m_slots[idx] = 4'(nib);
                m_mask[idx]  = 1'b1;
                if (m_mask == 4'hF) begin
                    exp_word  = {m_slots[3], m_slots[2], m_slots[1], m_slots[0]};
                    exp_valid = 1'b1;
                    m_mask    = 4'h0;
                end
            end else begin
                exp_err       = 1'b1;
                exp_err_digit = 2'(idx);
            end
        end
    endtask

    task automatic apply(input logic en, input logic [7:0] seg, input logic [3:0] sel);
        @(negedge clk);
        sample_en = en; seg_in = seg; dig_sel = sel;
        model_step(en, seg, sel);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_en = 1'b0; seg_in = 8'hFF; dig_sel = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({word_out, word_valid, err, err_digit} !== 20'h0) begin
            failures++;
            $display("FAIL reset_state: got w=%h v=%b e=%b ed=%0d, want all zero", word_out, word_valid, err, err_digit);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_scan();
        logic [7:0] pats [4] = '{8'h8E, 8'h86, 8'hA1, 8'hC6};
        int v_cnt = 0;
        for (int d = 0; d < 4; d++) begin
            for (int n = 0; n < 4; n++) begin
                apply(1'b1, pats[d], 4'(1 << d));
                v_cnt += int'(word_valid);
                checks++;
                if ({word_valid, err, word_out, err_digit} !== {exp_valid, exp_err, exp_word, exp_err_digit}) begin
                    failures++;
                    $display("FAIL scan_step d=%0d n=%0d: got v=%b e=%b w=%h ed=%0d, want v=%b e=%b w=%h ed=%0d",
                             d, n, word_valid, err, word_out, err_digit, exp_valid, exp_err, exp_word, exp_err_digit);
                end
                // Non-strobe cycle with a different pattern must neither advance nor break the run.
                apply(1'b0, 8'hFF, 4'(1 << ((d + 1) % 4)));
                v_cnt += int'(word_valid);
                checks++;
                if ({word_valid, err} !== {exp_valid, exp_err}) begin
                    failures++;
                    $display("FAIL scan_gap d=%0d: got v=%b e=%b, want v=%b e=%b", d, word_valid, err, exp_valid, exp_err);
                end
            end
            $display("scan digit %0d pattern %h", d, pats[d]);
        end
        checks++;
        if (word_out !== 16'hCDEF || v_cnt != 1) begin
            failures++;
            $display("FAIL scan_word: got w=%h pulses=%0d, want w=cdef pulses=1", word_out, v_cnt);
        end
    endtask

    task automatic test_unstable();
        logic [3:0] bsel [5] = '{4'b0010, 4'b0010, 4'b0001, 4'b0100, 4'b1000};
        logic [7:0] bseg [5] = '{8'h99, 8'h92, 8'hC0, 8'hA4, 8'hB0};
        int         bn   [5] = '{3, 4, 4, 4, 4};
        int v_cnt = 0;
        for (int b = 0; b < 5; b++) begin
            for (int n = 0; n < bn[b]; n++) begin
                apply(1'b1, bseg[b], bsel[b]);
                v_cnt += int'(word_valid);
                checks++;
                if ({word_valid, err, word_out, err_digit} !== {exp_valid, exp_err, exp_word, exp_err_digit}) begin
                    failures++;
                    $display("FAIL unstable_step b=%0d n=%0d: got v=%b e=%b w=%h ed=%0d, want v=%b e=%b w=%h ed=%0d",
                             b, n, word_valid, err, word_out, err_digit, exp_valid, exp_err, exp_word, exp_err_digit);
                end
            end
            $display("unstable burst sel=%b seg=%h x%0d", bsel[b], bseg[b], bn[b]);
        end
        checks++;
        if (word_out !== 16'h3250 || v_cnt != 1) begin
            failures++;
            $display("FAIL unstable_word: got w=%h pulses=%0d, want w=3250 pulses=1", word_out, v_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] bsel [5] = '{4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b0100};
        logic [7:0] bseg [5] = '{8'hF9, 8'hA4, 8'h99, 8'h7F, 8'hC0};
        int v_cnt = 0;
        int e_cnt = 0;
        for (int b = 0; b < 5; b++) begin
            for (int n = 0; n < 4; n++) begin
                apply(1'b1, bseg[b], bsel[b]);
                v_cnt += int'(word_valid);
                e_cnt += int'(err);
                checks++;
                if ({word_valid, err, word_out, err_digit} !== {exp_valid, exp_err, exp_word, exp_err_digit}) begin
                    failures++;
                    $display("FAIL illegal_step b=%0d n=%0d: got v=%b e=%b w=%h ed=%0d, want v=%b e=%b w=%h ed=%0d",
                             b, n, word_valid, err, word_out, err_digit, exp_valid, exp_err, exp_word, exp_err_digit);
                end
            end
            if (b == 3) begin
                checks++;
                if (e_cnt != 1 || err_digit !== 2'd2 || v_cnt != 0) begin
                    failures++;
                    $display("FAIL illegal_err: got errs=%0d ed=%0d pulses=%0d, want errs=1 ed=2 pulses=0", e_cnt, err_digit, v_cnt);
                end
            end
            $display("illegal burst sel=%b seg=%h", bsel[b], bseg[b]);
        end
        checks++;
        if (word_out !== 16'h4021 || v_cnt != 1) begin
            failures++;
            $display("FAIL illegal_word: got w=%h pulses=%0d, want w=4021 pulses=1", word_out, v_cnt);
        end
    endtask

    task automatic test_multihot();
        logic [3:0] bsel [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0011, 4'b0001, 4'b0001};
        logic [7:0] bseg [7] = '{8'hF9, 8'hF9, 8'hF9, 8'h80, 8'h80, 8'h80, 8'h80};
        int         bn   [7] = '{4, 4, 4, 2, 1, 3, 1};
        int v_cnt = 0;
        for (int b = 0; b < 7; b++) begin
            for (int n = 0; n < bn[b]; n++) begin
                apply(1'b1, bseg[b], bsel[b]);
                v_cnt += int'(word_valid);
                checks++;
                if ({word_valid, err, word_out, err_digit} !== {exp_valid, exp_err, exp_word, exp_err_digit}) begin
                    failures++;
                    $display("FAIL multihot_step b=%0d n=%0d: got v=%b e=%b w=%h ed=%0d, want v=%b e=%b w=%h ed=%0d",
                             b, n, word_valid, err, word_out, err_digit, exp_valid, exp_err, exp_word, exp_err_digit);
                end
            end
            if (b == 5) begin
                checks++;
                if (v_cnt != 0) begin
                    failures++;
                    $display("FAIL multihot_early: got pulses=%0d after 3 post-reset samples, want 0", v_cnt);
                end
            end
            $display("multihot burst sel=%b seg=%h x%0d", bsel[b], bseg[b], bn[b]);
        end
        checks++;
        if (word_out !== 16'h1118 || v_cnt != 1) begin
            failures++;
            $display("FAIL multihot_word: got w=%h pulses=%0d, want w=1118 pulses=1", word_out, v_cnt);
        end
    endtask

    task automatic test_dot();
        logic [3:0] bsel [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] bseg [9] = '{8'h40, 8'hC0, 8'h40, 8'hC0, 8'h40, 8'h80, 8'h80, 8'h80, 8'hC0};
        int         bn   [9] = '{1, 1, 1, 1, 4, 4, 4, 4, 4};
        int v_cnt = 0;
        int e_cnt = 0;
        int e_want;
`ifdef SEG7_DOT_IGNORE_EN
        e_want = 0;
`else
        e_want = 1;
`endif
        for (int b = 0; b < 9; b++) begin
            for (int n = 0; n < bn[b]; n++) begin
                apply(1'b1, bseg[b], bsel[b]);
                v_cnt += int'(word_valid);
                e_cnt += int'(err);
                checks++;
                if ({word_valid, err, word_out, err_digit} !== {exp_valid, exp_err, exp_word, exp_err_digit}) begin
                    failures++;
                    $display("FAIL dot_step b=%0d n=%0d: got v=%b e=%b w=%h ed=%0d, want v=%b e=%b w=%h ed=%0d",
                             b, n, word_valid, err, word_out, err_digit, exp_valid, exp_err, exp_word, exp_err_digit);
                end
            end
            $display("dot burst sel=%b seg=%h x%0d", bsel[b], bseg[b], bn[b]);
        end
        checks++;
        if (word_out !== 16'h8880 || v_cnt != 1 || e_cnt != e_want) begin
            failures++;
            $display("FAIL dot_summary: got w=%h pulses=%0d errs=%0d, want w=8880 pulses=1 errs=%0d", word_out, v_cnt, e_cnt, e_want);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] bsel [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [7:0] bseg [4] = '{8'hF8, 8'h82, 8'h80, 8'h98};
        int v_cnt = 0;
        for (int n = 0; n < 4; n++) apply(1'b1, 8'h80, 4'b0001);
        for (int n = 0; n < 4; n++) apply(1'b1, 8'h98, 4'b0010);
        for (int n = 0; n < 2; n++) apply(1'b1, 8'hF8, 4'b0100);
        @(negedge clk);
        sample_en = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({word_out, word_valid, err, err_digit} !== 20'h0) begin
            failures++;
            $display("FAIL reset_async: got w=%h v=%b e=%b ed=%0d, want all zero", word_out, word_valid, err, err_digit);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("mid-track reset applied");
        for (int b = 0; b < 4; b++) begin
            for (int n = 0; n < 4; n++) begin
                apply(1'b1, bseg[b], bsel[b]);
                v_cnt += int'(word_valid);
                checks++;
                if ({word_valid, err, word_out, err_digit} !== {exp_valid, exp_err, exp_word, exp_err_digit}) begin
                    failures++;
                    $display("FAIL rescan_step b=%0d n=%0d: got v=%b e=%b w=%h ed=%0d, want v=%b e=%b w=%h ed=%0d",
                             b, n, word_valid, err, word_out, err_digit, exp_valid, exp_err, exp_word, exp_err_digit);
                end
            end
            $display("rescan burst sel=%b seg=%h", bsel[b], bseg[b]);
        end
        checks++;
        if (word_out !== 16'h6798 || v_cnt != 1) begin
            failures++;
            $display("FAIL rescan_word: got w=%h pulses=%0d, want w=6798 pulses=1", word_out, v_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] seg;
        logic [3:0] sel;
        logic       en;
        int         reps;
        for (int b = 0; b < 150; b++) begin
            seg = ($urandom_range(0, 9) < 8) ? glyphs[$urandom_range(0, 15)] : 8'($urandom);
            if ($urandom_range(0, 9) == 0) seg[7] = 1'b0;
            sel  = 4'(1 << $urandom_range(0, 3));
            reps = $urandom_range(1, 6);
            for (int n = 0; n < reps; n++) begin
                en = 1'b1;
                case ($urandom_range(0, 19))
                    0:       sel = 4'($urandom) | 4'b0101;
                    1, 2, 3: en = 1'b0;
                    default: ;
                endcase
                apply(en, seg, sel);
                checks++;
                if ({word_valid, err, word_out, err_digit} !== {exp_valid, exp_err, exp_word, exp_err_digit}) begin
                    failures++;
                    $display("FAIL random_step b=%0d n=%0d: got v=%b e=%b w=%h ed=%0d, want v=%b e=%b w=%h ed=%0d",
                             b, n, word_valid, err, word_out, err_digit, exp_valid, exp_err, exp_word, exp_err_digit);
                end
                if ($countones(sel) != 1) sel = 4'(1 << $urandom_range(0, 3));
            end
            $display("random burst %0d seg=%h sel=%b x%0d", b, seg, sel, reps);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_unstable();
        test_illegal();
        test_multihot();
        test_dot();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Recovers hex data from an active-low 8-bit seven-segment bus driven by a time-multiplexed display. Sits beside the S-DES board display path and reads back the digit patterns actually shown, for self-check and logging. It applies a per-digit stability filter, decodes each pattern to a nibble, assembles all digits into one word, and flags patterns that are not legal hex glyphs.

## Interface
- DIGITS, 4: number of multiplexed digits; word width is 4*DIGITS.
- STABLE_CYCLES, 4: matching sample strobes required before a digit is captured; legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- seg_in  in  8  segment bus, active-low; bit 7 is dot, bits 6:0 are segments g..a.
- dig_sel  in  DIGITS  digit enable, active-high, one-hot when valid.
- sample_en  in  1  single-cycle sample strobe.
- word_out  out  4*DIGITS  assembled word; digit i occupies [4i+3:4i].
- word_valid  out  1  one-cycle pulse: word_out has been refreshed.
- err  out  1  one-cycle pulse: stable pattern not a legal glyph.
- err_digit  out  $clog2(DIGITS)  index of the offending digit; holds until the next err.

## Operation
- Legal glyphs (seg_in hex -> nibble): C0->0, F9->1, A4->2, B0->3, 99->4, 92->5, 82->6, F8->7, 80->8, 98->9, 88->A, 83->B, C6->C, A1->D, 86->E, 8E->F. 7F (dot only) and every other code are illegal.
- A sample qualifies only when sample_en=1 and dig_sel is one-hot. A zero or multi-hot dig_sel on a strobe returns the filter to IDLE.
- Filter FSM:
  - IDLE: on a qualifying sample, latch seg_in and dig_sel, set count=1, go to TRACK.
  - TRACK: on a qualifying sample equal to the latched pair, increment count; any differing pair reloads, sets count=1 and stays in TRACK. When count reaches STABLE_CYCLES, evaluate and go to LOCKED.
  - LOCKED: equal samples are ignored, so no repeat capture occurs. A differing qualifying sample reloads and goes to TRACK.
- With STABLE_CYCLES=1, the first qualifying sample evaluates immediately.
- Evaluation outcomes:
  - Legal glyph: store the nibble in slot i and set captured bit i. Recapturing an already-captured slot overwrites it.
  - Illegal glyph: pulse err, load err_digit=i, leave the slot and its captured bit unchanged.
- When all captured bits are set, load word_out from the slots, pulse word_valid, and clear the captured mask.
- Reset values: word_out=0, word_valid=0, err=0, err_digit=0, slots=0, mask=0, count=0, state IDLE.
- A reset during TRACK discards the partial count and partial word.

## Timing
- All outputs are registered.
- Capture occurs on the clock edge that samples the STABLE_CYCLES-th matching strobe.
- word_valid and err are high for exactly the one cycle following that edge. word_out changes on that same edge.
- If the final missing digit completes on the same edge as an err for another digit, both pulses are asserted together (not possible with one-hot selection, but stated for completeness).
- Non-strobe cycles never advance the count.
- seg_in and dig_sel are sampled synchronously; the source synchronises them to clk.

## Configuration
- SEG7_DOT_IGNORE_EN defined: seg_in[7] is forced to 1 before comparison and decode, so a lit dot neither breaks stability nor makes a glyph illegal. 7F then decodes as illegal via bits 6:0 = 7F.
- Undefined: all 8 bits participate, and any glyph with the dot lit is illegal.

## Structure
- Package seg7_pkg holds:
  - the 16 glyph constants;
  - SEG7_DOT = 8'h7F;
  - the filter state enum (IDLE, TRACK, LOCKED).
- Sub-module seg7_glyph_decode: combinational, 8-bit pattern -> {legal, nibble}, built on seg7_pkg constants.
- The top holds the FSM, counter, slot registers, mask, and output registers.

## Test plan
- DIGITS=4, STABLE_CYCLES=4; digits 0..3 driven with 8E, 86, A1, C6, four strobes each -> one word_valid pulse with word_out=16'hCDEF.
- Digit 1 shown with 99 for three strobes, then 92 for four strobes -> slot 1 = 5; no capture of 4.
- Digit 2 held at 7F for four strobes -> err pulse with err_digit=2; no word_valid until a legal digit 2 follows.
- dig_sel=4'b0011 on a strobe mid-TRACK -> count resets; the next four legal samples are needed before capture.
- With SEG7_DOT_IGNORE_EN, digit 0 alternating 40/C0 for four strobes -> captures 0. Without the macro -> never stable, and an isolated four-strobe run of 40 raises err.
- rst asserted after two of three digits are captured -> all outputs 0 immediately; the next full scan of 80, 98, F8, 82 yields word_out=16'h6798.
